pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h1c000000, SHALL be the fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 redirect_valid  input  1  mispredict/flush redirect (branch_mistaken of the branch controller).
REQ-005 redirect_target  input  32  corrected fetch PC.
REQ-006 req_valid  output  1  icache fetch request valid.
REQ-007 req_ready  input  1  icache accepts the request this cycle.
REQ-008 req_pc  output  32  request address, 8-byte aligned (bits [2:0] = 0).
REQ-009 resp_valid  input  1  icache returns one in-order response.
REQ-010 resp_data  input  64  word at req_pc in [31:0], word at req_pc+4 in [63:32].
REQ-011 out_valid  output  1  fetch group valid toward instruction buffer.
REQ-012 out_ready  input  1  instruction buffer accepts the group.
REQ-013 out_pc  output  32  PC of inst0.
REQ-014 out_inst0 / out_inst1  output  32 each  instructions at out_pc and out_pc+4.
REQ-015 out_inst1_valid  output  1  inst1 present.

Function
REQ-016 Fetch PC register SHALL hold the next address to request; req_pc = {pc[31:3],3'b0}.
REQ-017 Request handshake SHALL complete when req_valid && req_ready; pc then advances to pc+8 if pc[2]=0, else to pc+4.
REQ-018 req_valid SHALL be 1 only when inflight_cnt + fifo_cnt < 2 and redirect_valid = 0.
REQ-019 Accepted requests SHALL push their full pc into a 2-entry in-flight PC queue; inflight_cnt range 0..2.
REQ-020 Each resp_valid SHALL pop the in-flight queue and decrement inflight_cnt; resp_valid with inflight_cnt = 0 is illegal.
REQ-021 A popped response with discard_cnt > 0 SHALL be dropped and discard_cnt decremented; otherwise pushed into a 2-entry output FIFO.
REQ-022 FIFO entry: pc, inst0 = pc[2] ? data[63:32] : data[31:0], inst1 = data[63:32], inst1_valid = !pc[2].
REQ-023 out_* SHALL present the FIFO head combinationally; out_valid = fifo_cnt != 0; pop on out_valid && out_ready.
REQ-024 Push and pop in the same cycle SHALL be allowed at any fifo_cnt, including full (fifo_cnt stays 2 via credit rule, no overflow).
REQ-025 Latency: response at cycle N SHALL be visible on out_* at cycle N+1 when FIFO empty.
REQ-026 On redirect_valid: pc <= redirect_target; FIFO cleared; any response in that cycle dropped; discard_cnt <= inflight_cnt - (resp_valid ? 1 : 0) after accounting for this cycle's pop, minus nothing for the suppressed request.
REQ-027 Redirect SHALL override all other pc updates in the same cycle; back-to-back redirects SHALL each re-steer pc, discard_cnt saturating at inflight_cnt.
REQ-028 Invariant: discard_cnt <= inflight_cnt at all times.
REQ-029 Misaligned redirect_target[1:0] != 0 SHALL be fetched as-is (exception detection is downstream).

Reset
REQ-030 Reset SHALL set pc = RESET_PC, inflight_cnt = discard_cnt = fifo_cnt = 0, FIFO pointers = 0.
REQ-031 During/after reset: req_valid = 0 while reset asserted, out_valid = 0, out_pc/out_inst* = 0; reset mid-operation abandons all in-flight requests; responses received while inflight_cnt = 0 after reset SHALL be ignored.

Structure
REQ-032 Shared package SHALL hold RESET_PC default and the fetch-group struct (pc, inst0, inst1, inst1_valid).
REQ-033 The 2-entry FIFO SHALL be one sub-module, fetch_fifo, parameterised by payload width; in-flight PC queue reuses it.

Verification
REQ-034 Reset release, req_ready=1, 1-cycle icache: req_pc 1c000000, 1c000008, 1c000010; out groups in order, inst1_valid=1.
REQ-035 redirect_target 1c000104: next req_pc 1c000100, out_inst0 = data[63:32], inst1_valid=0; following req_pc 1c000108.
REQ-036 Two requests in flight, redirect to 1c002000: both old responses dropped, first out_pc = 1c002000.
REQ-037 out_ready=0 for 10 cycles: at most 2 outstanding+buffered, req_valid=0, no group lost or duplicated.
REQ-038 Redirect coincident with resp_valid and req_ready: response dropped, no request issued, discard_cnt = inflight_cnt-1.
REQ-039 Reset asserted asynchronously mid-stream with 2 in flight: outputs zero immediately, fetch restarts at 1c000000.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared reset address and fetch-group payload for the fetch front end
package pc_gen_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic        inst1_valid;
  } fetch_group_t;
endpackage

// File: rtl/pc_gen_fifo.sv
// fetch_fifo: 2-entry FIFO with simultaneous push/pop at any fill level
module fetch_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);
  logic [W-1:0] mem [2];
  logic wp, rp, do_push, do_pop;
  assign do_pop  = pop && cnt != 2'd0;
  assign do_push = push && (cnt != 2'd2 || do_pop);
  assign dout    = cnt != 2'd0 ? mem[rp] : '0;
  // pointers and occupancy; clear empties the queue without touching storage
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else if (clr) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (do_push) wp <= !wp;
      if (do_pop) rp <= !rp;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  // payload storage, only valid entries are ever observed
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wp] <= din;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with credit-limited icache requests and redirect discard
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_pc,
  input  logic        resp_valid,
  input  logic [63:0] resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic        out_inst1_valid
);
  logic [31:0] pc, rsp_pc;
  logic [1:0] inflight_cnt, fifo_cnt, discard_cnt;
  logic req_fire, resp_pop;
  fetch_group_t grp_in, grp_out;
  assign req_valid = !reset && !redirect_valid && ({1'b0, inflight_cnt} + {1'b0, fifo_cnt} < 3'd2);
  assign req_pc    = {pc[31:3], 3'b000};
  assign req_fire  = req_valid && req_ready;
  assign resp_pop  = resp_valid && inflight_cnt != 2'd0;
  assign grp_in    = '{pc: rsp_pc,
                       inst0: rsp_pc[2] ? resp_data[63:32] : resp_data[31:0],
                       inst1: resp_data[63:32],
                       inst1_valid: !rsp_pc[2]};
  assign out_valid       = fifo_cnt != 2'd0;
  assign out_pc          = grp_out.pc;
  assign out_inst0       = grp_out.inst0;
  assign out_inst1       = grp_out.inst1;
  assign out_inst1_valid = grp_out.inst1_valid;
  fetch_fifo #(.W(32)) u_inflight (
    .clk(clk), .reset(reset), .clr(1'b0),
    .push(req_fire), .pop(resp_pop), .din(pc), .dout(rsp_pc), .cnt(inflight_cnt)
  );
  fetch_fifo #(.W($bits(fetch_group_t))) u_out (
    .clk(clk), .reset(reset), .clr(redirect_valid),
    .push(resp_pop && discard_cnt == 2'd0 && !redirect_valid),
    .pop(out_valid && out_ready), .din(grp_in), .dout(grp_out), .cnt(fifo_cnt)
  );
  // fetch pc: redirect wins, otherwise step to the next aligned 8-byte group
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_target;
    else if (req_fire) pc <= pc + (pc[2] ? 32'd4 : 32'd8);
  // responses still owed to pre-redirect requests that must be thrown away
  always_ff @(posedge clk or posedge reset)
    if (reset) discard_cnt <= 2'd0;
    else if (redirect_valid) discard_cnt <= inflight_cnt - {1'b0, resp_pop};
    else if (resp_pop && discard_cnt != 2'd0) discard_cnt <= discard_cnt - 2'd1;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen with a 1-cycle icache model
module tb_pc_gen;
  import pc_gen_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic redirect_valid = 1'b0, req_ready = 1'b0, resp_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [63:0] resp_data = '0;
  logic req_valid, out_valid, out_inst1_valid;
  logic [31:0] req_pc, out_pc, out_inst0, out_inst1;
  logic c_rr = 1'b0, c_or = 1'b0, c_rv = 1'b0, resp_en = 1'b0;
  logic [31:0] c_rt = '0;
  logic [31:0] pq[$], erq[$];
  fetch_group_t exq[$];
  int checks = 0, errors = 0, fired = 0, s;
  pc_gen dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst0(out_inst0), .out_inst1(out_inst1), .out_inst1_valid(out_inst1_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hc3c3_5a5a;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic exp_grp(input logic [31:0] pc, input logic i1v);
    exq.push_back('{pc: pc, inst0: word(pc), inst1: i1v ? word(pc + 32'd4) : word(pc), inst1_valid: i1v});
  endtask
  task automatic cyc();
    logic [31:0] a;
    @(negedge clk);
    req_ready = c_rr;
    out_ready = c_or;
    redirect_valid = c_rv;
    redirect_target = c_rt;
    if (resp_en && pq.size() != 0) begin
      a = pq.pop_front();
      resp_valid = 1'b1;
      resp_data = {word(a + 32'd4), word(a)};
    end else begin
      resp_valid = 1'b0;
      resp_data = '0;
    end
    #1;
    if (req_valid && req_ready) begin
      fired++;
      pq.push_back(req_pc);
      if (erq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got %h expected no request", req_pc);
      end else chk("req_pc", req_pc, erq.pop_front());
    end
  endtask
  task automatic fetch_n(input int n);
    int t;
    t = fired + n;
    c_rr = 1'b1;
    for (int i = 0; i < 60 && fired < t; i++) cyc();
    c_rr = 1'b0;
    chk("fetch_count", fired, t);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc();
  endtask
  always @(negedge clk) begin
    fetch_group_t g;
    #2;
    if (out_valid && out_ready) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got pc %h expected no group", out_pc);
      end else begin
        g = exq.pop_front();
        chk("out_pc", out_pc, g.pc);
        chk("out_inst0", out_inst0, g.inst0);
        chk("out_inst1", out_inst1, g.inst1);
        chk("out_inst1_valid", {31'd0, out_inst1_valid}, {31'd0, g.inst1_valid});
      end
    end
  end
  initial begin
    idle(2);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst0", out_inst0, 32'd0);
    reset = 1'b0;
    c_or = 1'b1;
    resp_en = 1'b1;
    erq.push_back(32'h1c000000); erq.push_back(32'h1c000008); erq.push_back(32'h1c000010);
    exp_grp(32'h1c000000, 1'b1); exp_grp(32'h1c000008, 1'b1); exp_grp(32'h1c000010, 1'b1);
    fetch_n(3);
    idle(4);
    c_rv = 1'b1; c_rt = 32'h1c000104;
    cyc();
    c_rv = 1'b0;
    erq.push_back(32'h1c000100); erq.push_back(32'h1c000108);
    exp_grp(32'h1c000104, 1'b0); exp_grp(32'h1c000108, 1'b1);
    fetch_n(2);
    idle(4);
    resp_en = 1'b0;
    erq.push_back(32'h1c000110); erq.push_back(32'h1c000118);
    fetch_n(2);
    c_rv = 1'b1; c_rt = 32'h1c002000;
    cyc();
    c_rv = 1'b0;
    cyc();
    chk("discard_two", {30'd0, dut.discard_cnt}, 32'd2);
    resp_en = 1'b1;
    erq.push_back(32'h1c002000);
    exp_grp(32'h1c002000, 1'b1);
    fetch_n(1);
    idle(4);
    c_or = 1'b0;
    erq.push_back(32'h1c002008); erq.push_back(32'h1c002010);
    exp_grp(32'h1c002008, 1'b1); exp_grp(32'h1c002010, 1'b1);
    fetch_n(2);
    s = fired;
    c_rr = 1'b1;
    idle(10);
    chk("stall_no_req", fired, s);
    chk("stall_req_valid", {31'd0, req_valid}, 32'd0);
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    c_rr = 1'b0;
    c_or = 1'b1;
    idle(4);
    resp_en = 1'b0;
    erq.push_back(32'h1c002018); erq.push_back(32'h1c002020);
    fetch_n(2);
    c_rv = 1'b1; c_rt = 32'h1c003000; resp_en = 1'b1; c_rr = 1'b1;
    cyc();
    chk("redir_req_valid", {31'd0, req_valid}, 32'd0);
    c_rv = 1'b0; c_rr = 1'b0;
    cyc();
    chk("discard_one", {30'd0, dut.discard_cnt}, 32'd1);
    erq.push_back(32'h1c003000);
    exp_grp(32'h1c003000, 1'b1);
    fetch_n(1);
    idle(4);
    c_or = 1'b0;
    erq.push_back(32'h1c003008);
    fetch_n(1);
    idle(2);
    resp_en = 1'b0;
    erq.push_back(32'h1c003010);
    fetch_n(1);
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_req_valid", {31'd0, req_valid}, 32'd0);
    chk("async_out_pc", out_pc, 32'd0);
    chk("async_out_inst0", out_inst0, 32'd0);
    chk("async_discard", {30'd0, dut.discard_cnt}, 32'd0);
    pq.delete();
    idle(2);
    reset = 1'b0;
    c_or = 1'b1;
    resp_en = 1'b1;
    erq.push_back(32'h1c000000);
    exp_grp(32'h1c000000, 1'b1);
    fetch_n(1);
    idle(5);
    chk("groups_drained", exq.size(), 32'd0);
    chk("reqs_drained", erq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
